// File: rtl/sy_pkg.sv
// Shared core types; this slice adds the MDU issue-queue sizing and entry layout.
package sy_pkg;

   localparam int PHY_REG_WTH  = 6;
   localparam int ROB_WTH      = 5;
   localparam int DWTH         = 64;
   localparam int MDU_IQ_DEPTH = 4;
   localparam int MDU_NUM_WAKE = 3;

   typedef enum logic [1:0] {
      MDU_MUL  = 2'd0,
      MDU_MULH = 2'd1,
      MDU_DIV  = 2'd2,
      MDU_REM  = 2'd3
   } mdu_opcode_e;

   typedef struct packed {
      mdu_opcode_e            opcode;
      logic                   rs1_sign;
      logic                   rs2_sign;
      logic [PHY_REG_WTH-1:0] rs1_idx;
      logic                   rs1_rdy;
      logic [PHY_REG_WTH-1:0] rs2_idx;
      logic                   rs2_rdy;
      logic [PHY_REG_WTH-1:0] rdst_idx;
      logic                   is_32;
      logic [ROB_WTH-1:0]     rob_idx;
   } mdu_iq_entry_t;

   function automatic logic is_div_op(input mdu_opcode_e op);
      return (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/sy_ppl_mdu_iq_wakeup.sv
// Wake-up comparator array: every queued source index and the dispatching
// sources are matched against all wake-up buses.
module sy_ppl_mdu_iq_wakeup
   import sy_pkg::*;
#(
   parameter int DEPTH    = MDU_IQ_DEPTH,
   parameter int NUM_WAKE = MDU_NUM_WAKE
) (
   input  logic [DEPTH-1:0][PHY_REG_WTH-1:0]    i_rs1_idx,
   input  logic [DEPTH-1:0][PHY_REG_WTH-1:0]    i_rs2_idx,
   input  logic [PHY_REG_WTH-1:0]               i_disp_rs1_idx,
   input  logic [PHY_REG_WTH-1:0]               i_disp_rs2_idx,
   input  logic [NUM_WAKE-1:0]                  i_wake_vld,
   input  logic [NUM_WAKE-1:0][PHY_REG_WTH-1:0] i_wake_idx,
   output logic [DEPTH-1:0]                     o_set_rs1,
   output logic [DEPTH-1:0]                     o_set_rs2,
   output logic                                 o_disp_rs1_hit,
   output logic                                 o_disp_rs2_hit
);

   always_comb begin
      o_set_rs1      = '0;
      o_set_rs2      = '0;
      o_disp_rs1_hit = 1'b0;
      o_disp_rs2_hit = 1'b0;
      for (int k = 0; k < NUM_WAKE; k++) begin
         if (i_wake_vld[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (i_wake_idx[k] == i_rs1_idx[i]) o_set_rs1[i] = 1'b1;
               if (i_wake_idx[k] == i_rs2_idx[i]) o_set_rs2[i] = 1'b1;
            end
            if (i_wake_idx[k] == i_disp_rs1_idx) o_disp_rs1_hit = 1'b1;
            if (i_wake_idx[k] == i_disp_rs2_idx) o_disp_rs2_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sy_ppl_mdu_iq.sv
// In-order MDU issue queue with head-only select and a registered issue stage.
// Optional empty-queue bypass is enabled by defining SY_MDU_IQ_BYPASS_EN.
module sy_ppl_mdu_iq
   import sy_pkg::*;
#(
   parameter int DEPTH    = MDU_IQ_DEPTH,
   parameter int NUM_WAKE = MDU_NUM_WAKE
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 flush_i,
   input  logic                                 disp_vld_i,
   output logic                                 disp_rdy_o,
   input  mdu_opcode_e                          disp_opcode_i,
   input  logic                                 disp_rs1_sign_i,
   input  logic                                 disp_rs2_sign_i,
   input  logic [PHY_REG_WTH-1:0]               disp_rs1_idx_i,
   input  logic [PHY_REG_WTH-1:0]               disp_rs2_idx_i,
   input  logic                                 disp_rs1_rdy_i,
   input  logic                                 disp_rs2_rdy_i,
   input  logic [PHY_REG_WTH-1:0]               disp_rdst_idx_i,
   input  logic                                 disp_is_32_i,
   input  logic [ROB_WTH-1:0]                   disp_rob_idx_i,
   input  logic [NUM_WAKE-1:0]                  wake_vld_i,
   input  logic [NUM_WAKE-1:0][PHY_REG_WTH-1:0] wake_idx_i,
   output logic [PHY_REG_WTH-1:0]               iq_gpr__rs1_idx_o,
   output logic [PHY_REG_WTH-1:0]               iq_gpr__rs2_idx_o,
   input  logic [DWTH-1:0]                      gpr_iq__rs1_data_i,
   input  logic [DWTH-1:0]                      gpr_iq__rs2_data_i,
   input  logic                                 div_busy_i,
   input  logic                                 div_wb_stall_i,
   output logic                                 mdu_en_o,
   output mdu_opcode_e                          mdu_opcode_o,
   output logic                                 mdu_rs1_sign_o,
   output logic                                 mdu_rs2_sign_o,
   output logic [DWTH-1:0]                      mdu_rs1_data_o,
   output logic [DWTH-1:0]                      mdu_rs2_data_o,
   output logic [PHY_REG_WTH-1:0]               mdu_rdst_idx_o,
   output logic                                 mdu_is_32_o,
   output logic [ROB_WTH-1:0]                   mdu_rob_idx_o,
   output logic                                 iq_empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   mdu_iq_entry_t                    r_ent [DEPTH];
   logic [AW:0]                      r_wptr, r_rptr;
   logic                             r_div_pend;
   logic                             r_mdu_en;
   mdu_opcode_e                      r_mdu_opcode;
   logic                             r_mdu_rs1_sign, r_mdu_rs2_sign;
   logic [DWTH-1:0]                  r_mdu_rs1_data, r_mdu_rs2_data;
   logic [PHY_REG_WTH-1:0]           r_mdu_rdst_idx;
   logic                             r_mdu_is_32;
   logic [ROB_WTH-1:0]               r_mdu_rob_idx;

   logic [DEPTH-1:0][PHY_REG_WTH-1:0] w_ent_rs1_idx, w_ent_rs2_idx;
   logic [DEPTH-1:0]                 w_set_rs1, w_set_rs2;
   logic                             w_disp_rs1_hit, w_disp_rs2_hit;
   logic                             w_full, w_empty;
   mdu_iq_entry_t                    w_head, w_disp_ent;
   logic                             w_head_hzd, w_sel_q, w_byp, w_sel, w_push;
   mdu_opcode_e                      w_sel_op;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ent_rs1_idx[i] = r_ent[i].rs1_idx;
         w_ent_rs2_idx[i] = r_ent[i].rs2_idx;
      end
   end

   sy_ppl_mdu_iq_wakeup #(
      .DEPTH    (DEPTH),
      .NUM_WAKE (NUM_WAKE)
   ) u_wakeup (
      .i_rs1_idx      (w_ent_rs1_idx),
      .i_rs2_idx      (w_ent_rs2_idx),
      .i_disp_rs1_idx (disp_rs1_idx_i),
      .i_disp_rs2_idx (disp_rs2_idx_i),
      .i_wake_vld     (wake_vld_i),
      .i_wake_idx     (wake_idx_i),
      .o_set_rs1      (w_set_rs1),
      .o_set_rs2      (w_set_rs2),
      .o_disp_rs1_hit (w_disp_rs1_hit),
      .o_disp_rs2_hit (w_disp_rs2_hit)
   );

   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_empty = (r_wptr == r_rptr);
   assign w_head  = r_ent[r_rptr[AW-1:0]];

   always_comb begin
      w_disp_ent          = '0;
      w_disp_ent.opcode   = disp_opcode_i;
      w_disp_ent.rs1_sign = disp_rs1_sign_i;
      w_disp_ent.rs2_sign = disp_rs2_sign_i;
      w_disp_ent.rs1_idx  = disp_rs1_idx_i;
      w_disp_ent.rs1_rdy  = disp_rs1_rdy_i | w_disp_rs1_hit;
      w_disp_ent.rs2_idx  = disp_rs2_idx_i;
      w_disp_ent.rs2_rdy  = disp_rs2_rdy_i | w_disp_rs2_hit;
      w_disp_ent.rdst_idx = disp_rdst_idx_i;
      w_disp_ent.is_32    = disp_is_32_i;
      w_disp_ent.rob_idx  = disp_rob_idx_i;
   end

   // div_pend covers the cycles between a divide select and the MDU raising busy
   assign w_head_hzd = is_div_op(w_head.opcode) ? (!div_busy_i && !r_div_pend) : !div_wb_stall_i;
   assign w_sel_q    = !flush_i && !w_empty && w_head.rs1_rdy && w_head.rs2_rdy && w_head_hzd;

`ifdef SY_MDU_IQ_BYPASS_EN
   logic w_disp_hzd;
   assign w_disp_hzd = is_div_op(disp_opcode_i) ? (!div_busy_i && !r_div_pend) : !div_wb_stall_i;
   assign w_byp      = !flush_i && w_empty && disp_vld_i && disp_rs1_rdy_i && disp_rs2_rdy_i && w_disp_hzd;
`else
   assign w_byp      = 1'b0;
`endif

   assign w_sel    = w_sel_q || w_byp;
   assign w_sel_op = w_sel_q ? w_head.opcode : disp_opcode_i;
   assign w_push   = disp_vld_i && !w_full && !flush_i && !w_byp;

   assign disp_rdy_o        = !w_full;
   assign iq_empty_o        = w_empty;
   assign iq_gpr__rs1_idx_o = w_byp ? disp_rs1_idx_i : w_head.rs1_idx;
   assign iq_gpr__rs2_idx_o = w_byp ? disp_rs2_idx_i : w_head.rs2_idx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i].rs1_rdy <= r_ent[i].rs1_rdy | w_set_rs1[i];
            r_ent[i].rs2_rdy <= r_ent[i].rs2_rdy | w_set_rs2[i];
            if (w_push && (r_wptr[AW-1:0] == i[AW-1:0])) r_ent[i] <= w_disp_ent;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_div_pend <= 1'b0;
      end else if (flush_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_div_pend <= 1'b0;
      end else begin
         if (w_push)  r_wptr <= r_wptr + PTR_ONE;
         if (w_sel_q) r_rptr <= r_rptr + PTR_ONE;
         if (div_busy_i)                          r_div_pend <= 1'b0;
         else if (w_sel && is_div_op(w_sel_op))   r_div_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mdu_en       <= 1'b0;
         r_mdu_opcode   <= MDU_MUL;
         r_mdu_rs1_sign <= 1'b0;
         r_mdu_rs2_sign <= 1'b0;
         r_mdu_rs1_data <= '0;
         r_mdu_rs2_data <= '0;
         r_mdu_rdst_idx <= '0;
         r_mdu_is_32    <= 1'b0;
         r_mdu_rob_idx  <= '0;
      end else begin
         r_mdu_en <= w_sel;
         if (w_sel) begin
            r_mdu_rs1_data <= gpr_iq__rs1_data_i;
            r_mdu_rs2_data <= gpr_iq__rs2_data_i;
            if (w_sel_q) begin
               r_mdu_opcode   <= w_head.opcode;
               r_mdu_rs1_sign <= w_head.rs1_sign;
               r_mdu_rs2_sign <= w_head.rs2_sign;
               r_mdu_rdst_idx <= w_head.rdst_idx;
               r_mdu_is_32    <= w_head.is_32;
               r_mdu_rob_idx  <= w_head.rob_idx;
            end else begin
               r_mdu_opcode   <= disp_opcode_i;
               r_mdu_rs1_sign <= disp_rs1_sign_i;
               r_mdu_rs2_sign <= disp_rs2_sign_i;
               r_mdu_rdst_idx <= disp_rdst_idx_i;
               r_mdu_is_32    <= disp_is_32_i;
               r_mdu_rob_idx  <= disp_rob_idx_i;
            end
         end
      end
   end

   assign mdu_en_o       = r_mdu_en;
   assign mdu_opcode_o   = r_mdu_opcode;
   assign mdu_rs1_sign_o = r_mdu_rs1_sign;
   assign mdu_rs2_sign_o = r_mdu_rs2_sign;
   assign mdu_rs1_data_o = r_mdu_rs1_data;
   assign mdu_rs2_data_o = r_mdu_rs2_data;
   assign mdu_rdst_idx_o = r_mdu_rdst_idx;
   assign mdu_is_32_o    = r_mdu_is_32;
   assign mdu_rob_idx_o  = r_mdu_rob_idx;

endmodule

// File: tb/tb_sy_ppl_mdu_iq.sv
// Bench for sy_ppl_mdu_iq: directed scenarios then random traffic, all checked
// against a queue-level reference model (honours SY_MDU_IQ_BYPASS_EN).
module tb_sy_ppl_mdu_iq;
   import sy_pkg::*;

   localparam int DEPTH = MDU_IQ_DEPTH;
`ifdef SY_MDU_IQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic                          clk_i = 1'b0;
   logic                          rst_ni;
   logic                          flush_i, disp_vld_i, disp_rdy_o;
   mdu_opcode_e                   disp_opcode_i;
   logic                          disp_rs1_sign_i, disp_rs2_sign_i;
   logic [PHY_REG_WTH-1:0]        disp_rs1_idx_i, disp_rs2_idx_i;
   logic                          disp_rs1_rdy_i, disp_rs2_rdy_i;
   logic [PHY_REG_WTH-1:0]        disp_rdst_idx_i;
   logic                          disp_is_32_i;
   logic [ROB_WTH-1:0]            disp_rob_idx_i;
   logic [2:0]                    wake_vld_i;
   logic [2:0][PHY_REG_WTH-1:0]   wake_idx_i;
   logic [PHY_REG_WTH-1:0]        iq_gpr__rs1_idx_o, iq_gpr__rs2_idx_o;
   logic [DWTH-1:0]               gpr_iq__rs1_data_i, gpr_iq__rs2_data_i;
   logic                          div_busy_i, div_wb_stall_i;
   logic                          mdu_en_o;
   mdu_opcode_e                   mdu_opcode_o;
   logic                          mdu_rs1_sign_o, mdu_rs2_sign_o;
   logic [DWTH-1:0]               mdu_rs1_data_o, mdu_rs2_data_o;
   logic [PHY_REG_WTH-1:0]        mdu_rdst_idx_o;
   logic                          mdu_is_32_o;
   logic [ROB_WTH-1:0]            mdu_rob_idx_o;
   logic                          iq_empty_o;

   logic [DWTH-1:0] rf [64];
   assign gpr_iq__rs1_data_i = rf[iq_gpr__rs1_idx_o];
   assign gpr_iq__rs2_data_i = rf[iq_gpr__rs2_idx_o];

   always #5 clk_i = ~clk_i;

   sy_ppl_mdu_iq dut (
      .clk_i, .rst_ni, .flush_i, .disp_vld_i, .disp_rdy_o, .disp_opcode_i,
      .disp_rs1_sign_i, .disp_rs2_sign_i, .disp_rs1_idx_i, .disp_rs2_idx_i,
      .disp_rs1_rdy_i, .disp_rs2_rdy_i, .disp_rdst_idx_i, .disp_is_32_i,
      .disp_rob_idx_i, .wake_vld_i, .wake_idx_i, .iq_gpr__rs1_idx_o,
      .iq_gpr__rs2_idx_o, .gpr_iq__rs1_data_i, .gpr_iq__rs2_data_i,
      .div_busy_i, .div_wb_stall_i, .mdu_en_o, .mdu_opcode_o, .mdu_rs1_sign_o,
      .mdu_rs2_sign_o, .mdu_rs1_data_o, .mdu_rs2_data_o, .mdu_rdst_idx_o,
      .mdu_is_32_o, .mdu_rob_idx_o, .iq_empty_o
   );

   typedef struct {
      mdu_opcode_e op;
      logic s1, s2;
      logic [5:0] i1, i2;
      logic r1, r2;
      logic [5:0] rd;
      logic w;
      logic [4:0] rob;
   } ment_t;

   ment_t mq[$];
   logic  m_pend = 1'b0;
   int    checks = 0, failures = 0;
   int    cyc_n = 0, n_en = 0, last_en_cyc = -1;
   int    en_log[$];
   logic  auto_busy = 1'b0;
   int    busy_at = 0, busy_end = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic woke(input logic [5:0] idx);
      for (int k = 0; k < 3; k++)
         if (wake_vld_i[k] && wake_idx_i[k] == idx) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic hz_ok(input mdu_opcode_e op);
      if (op == MDU_DIV || op == MDU_REM) return !div_busy_i && !m_pend;
      return !div_wb_stall_i;
   endfunction

   task automatic set_disp(input mdu_opcode_e op, input logic [5:0] i1, input logic [5:0] i2,
                           input logic r1, input logic r2);
      disp_vld_i      = 1'b1;
      disp_opcode_i   = op;
      disp_rs1_idx_i  = i1;
      disp_rs2_idx_i  = i2;
      disp_rs1_rdy_i  = r1;
      disp_rs2_rdy_i  = r2;
      disp_rs1_sign_i = 1'($urandom);
      disp_rs2_sign_i = 1'($urandom);
      disp_rdst_idx_i = 6'($urandom);
      disp_is_32_i    = 1'($urandom);
      disp_rob_idx_i  = 5'($urandom);
   endtask

   task automatic set_wake(input int k, input logic [5:0] idx);
      wake_vld_i[k] = 1'b1;
      wake_idx_i[k] = idx;
   endtask

   // One clock of DUT and model together; inputs are already applied.
   task automatic tick();
      ment_t d, e;
      logic  sel_q, byp, sel, push;
      int    sz;
      if (auto_busy) div_busy_i = (cyc_n >= busy_at) && (cyc_n < busy_end);
      #1;
      sz = mq.size();
      check("disp_rdy", disp_rdy_o, sz != DEPTH);
      check("iq_empty", iq_empty_o, sz == 0);
      d.op = disp_opcode_i; d.s1 = disp_rs1_sign_i; d.s2 = disp_rs2_sign_i;
      d.i1 = disp_rs1_idx_i; d.i2 = disp_rs2_idx_i;
      d.r1 = disp_rs1_rdy_i; d.r2 = disp_rs2_rdy_i;
      d.rd = disp_rdst_idx_i; d.w = disp_is_32_i; d.rob = disp_rob_idx_i;
      sel_q = !flush_i && sz > 0 && mq[0].r1 && mq[0].r2 && hz_ok(mq[0].op);
      byp = 1'b0;
`ifdef SY_MDU_IQ_BYPASS_EN
      byp = !flush_i && sz == 0 && disp_vld_i && d.r1 && d.r2 && hz_ok(d.op);
`endif
      if (byp) begin
         check("rd_addr1_byp", iq_gpr__rs1_idx_o, d.i1);
         check("rd_addr2_byp", iq_gpr__rs2_idx_o, d.i2);
      end else if (sz > 0) begin
         check("rd_addr1", iq_gpr__rs1_idx_o, mq[0].i1);
         check("rd_addr2", iq_gpr__rs2_idx_o, mq[0].i2);
      end
      sel  = sel_q || byp;
      e    = sel_q ? mq[0] : d;
      push = disp_vld_i && sz != DEPTH && !flush_i && !byp;
      d.r1 = d.r1 | woke(d.i1);
      d.r2 = d.r2 | woke(d.i2);
      if (flush_i) mq.delete();
      else begin
         if (sel_q) void'(mq.pop_front());
         foreach (mq[j]) begin
            mq[j].r1 = mq[j].r1 | woke(mq[j].i1);
            mq[j].r2 = mq[j].r2 | woke(mq[j].i2);
         end
         if (push) mq.push_back(d);
      end
      if (flush_i || div_busy_i) m_pend = 1'b0;
      else if (sel && (e.op == MDU_DIV || e.op == MDU_REM)) m_pend = 1'b1;
      if (sel && auto_busy && (e.op == MDU_DIV || e.op == MDU_REM)) begin
         busy_at  = cyc_n + 3;
         busy_end = busy_at + $urandom_range(1, 6);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      cyc_n++;
      check("mdu_en", mdu_en_o, sel);
      if (mdu_en_o) begin
         n_en++;
         last_en_cyc = cyc_n;
         en_log.push_back(cyc_n);
      end
      if (sel) begin
         check("mdu_opcode", mdu_opcode_o, e.op);
         check("mdu_sign1", mdu_rs1_sign_o, e.s1);
         check("mdu_sign2", mdu_rs2_sign_o, e.s2);
         check("mdu_data1", mdu_rs1_data_o, rf[e.i1]);
         check("mdu_data2", mdu_rs2_data_o, rf[e.i2]);
         check("mdu_rdst", mdu_rdst_idx_o, e.rd);
         check("mdu_is32", mdu_is_32_o, e.w);
         check("mdu_rob", mdu_rob_idx_o, e.rob);
      end
      disp_vld_i = 1'b0;
      wake_vld_i = '0;
      flush_i    = 1'b0;
   endtask

   initial begin
      int c0, n0, e1, cw;
      foreach (rf[i]) rf[i] = {$urandom, $urandom};
      rst_ni = 1'b0; flush_i = 1'b0; disp_vld_i = 1'b0; wake_vld_i = '0; wake_idx_i = '0;
      disp_opcode_i = MDU_MUL; disp_rs1_sign_i = 1'b0; disp_rs2_sign_i = 1'b0;
      disp_rs1_idx_i = '0; disp_rs2_idx_i = '0; disp_rs1_rdy_i = 1'b0; disp_rs2_rdy_i = 1'b0;
      disp_rdst_idx_i = '0; disp_is_32_i = 1'b0; disp_rob_idx_i = '0;
      div_busy_i = 1'b0; div_wb_stall_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_en", mdu_en_o, 1'b0);
      check("rst_data1", mdu_rs1_data_o, 64'h0);
      check("rst_rdst", mdu_rdst_idx_o, 6'h0);
      check("rst_rob", mdu_rob_idx_o, 5'h0);
      check("rst_opcode", mdu_opcode_o, MDU_MUL);
      check("rst_disp_rdy", disp_rdy_o, 1'b1);
      check("rst_empty", iq_empty_o, 1'b1);
      check("rst_rd_addr1", iq_gpr__rs1_idx_o, 6'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // single ready MUL
      set_disp(MDU_MUL, 6'd3, 6'd5, 1'b1, 1'b1);
      c0 = cyc_n; n0 = n_en;
      repeat (4) tick();
      check("t1_latency", last_en_cyc, c0 + LAT);
      check("t1_count", n_en - n0, 1);

      // operand woken four cycles after dispatch
      set_disp(MDU_MUL, 6'd7, 6'd9, 1'b1, 1'b0);
      n0 = n_en;
      repeat (4) tick();
      check("t2_no_early", n_en - n0, 0);
      set_wake(1, 6'd9);
      cw = cyc_n;
      repeat (4) tick();
      check("t2_latency", last_en_cyc, cw + 2);
      check("t2_count", n_en - n0, 1);

      // DIV then REM with a 20-cycle busy window
      set_disp(MDU_DIV, 6'd1, 6'd2, 1'b1, 1'b1);
      c0 = cyc_n; n0 = n_en;
      tick();
      set_disp(MDU_REM, 6'd4, 6'd6, 1'b1, 1'b1);
      tick();
      e1 = last_en_cyc;
      check("t3_div_latency", e1, c0 + LAT);
      for (int n = 0; n < 40; n++) begin
         div_busy_i = (cyc_n >= e1 + 2) && (cyc_n < e1 + 22);
         tick();
      end
      div_busy_i = 1'b0;
      check("t3_rem_cycle", last_en_cyc, e1 + 23);
      check("t3_count", n_en - n0, 2);

      // fill with waiting ops, reject a fifth, then wake everything
      n0 = n_en;
      for (int i = 0; i < 4; i++) begin
         set_disp(MDU_MUL, 6'(10 + i), 6'(20 + i), 1'b0, 1'b0);
         tick();
      end
      set_disp(MDU_MUL, 6'd30, 6'd31, 1'b1, 1'b1);
      check("t4_full_rdy", disp_rdy_o, 1'b0);
      tick();
      set_wake(0, 6'd10); set_wake(1, 6'd11); set_wake(2, 6'd12);
      tick();
      set_wake(0, 6'd13); set_wake(1, 6'd20); set_wake(2, 6'd21);
      tick();
      set_wake(0, 6'd22); set_wake(1, 6'd23);
      tick();
      repeat (6) tick();
      check("t4_count", n_en - n0, 4);
      check("t4_consecutive", en_log[$] - en_log[$-3], 3);
      check("t4_empty", iq_empty_o, 1'b1);

      // flush with three entries and a dropped dispatch
      for (int i = 0; i < 3; i++) begin
         set_disp(MDU_MULH, 6'(40 + 2 * i), 6'(41 + 2 * i), 1'b0, 1'b0);
         tick();
      end
      n0 = n_en;
      set_disp(MDU_MUL, 6'd50, 6'd51, 1'b1, 1'b1);
      flush_i = 1'b1;
      tick();
      check("t5_empty", iq_empty_o, 1'b1);
      check("t5_disp_rdy", disp_rdy_o, 1'b1);
      check("t5_en", mdu_en_o, 1'b0);
      set_wake(0, 6'd40); set_wake(1, 6'd41); set_wake(2, 6'd42);
      tick();
      set_wake(0, 6'd43); set_wake(1, 6'd44); set_wake(2, 6'd45);
      tick();
      repeat (4) tick();
      check("t5_no_issue", n_en - n0, 0);

      // writeback stall holds a MUL for two cycles
      div_wb_stall_i = 1'b1;
      set_disp(MDU_MUL, 6'd12, 6'd13, 1'b1, 1'b1);
      c0 = cyc_n; n0 = n_en;
      repeat (3) tick();
      div_wb_stall_i = 1'b0;
      repeat (3) tick();
      check("t6_latency", last_en_cyc, c0 + 4);
      check("t6_count", n_en - n0, 1);

      // random traffic
      auto_busy = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) != 0)
            set_disp(mdu_opcode_e'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
                     6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 3; k++) begin
            wake_vld_i[k] = ($urandom_range(0, 2) == 0);
            wake_idx_i[k] = 6'($urandom_range(0, 15));
         end
         flush_i        = ($urandom_range(0, 39) == 0);
         div_wb_stall_i = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
